cp0_exception_unit: RTL and testbench
=====================================

Name: cp0_exception_unit

Overview:
- Coprocessor-0 register file and exception arbiter at the memory stage of the 5-stage MIPS pipeline.
- Consumes the per-instruction exception/privileged flags generated in decode (syscall, break, reserved-instruction, eret, mtc0, mfc0), plus overflow, address-error and hardware-interrupt sources.
- Decides whether an exception is taken, updates the CP0 registers, and drives the pipeline flush and redirect PC.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC, and implements the Count/Compare timer.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect target for all exceptions and interrupts.
- STATUS_RST, 32'h0040_0000, reset value of Status (BEV=1).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- int_i  in  6  hardware interrupt lines (level)
- m_valid  in  1  M stage holds a real instruction (0 = bubble/flushed)
- m_pc  in  32  PC of the M-stage instruction
- m_in_delay_slot  in  1  M-stage instruction is in a branch delay slot
- m_syscall, m_break, m_reserve, m_eret  in  1 each  decode flags carried to M
- m_overflow  in  1  ALU signed overflow
- m_adel_if  in  1  misaligned fetch
- m_adel_data  in  1  misaligned load
- m_ades  in  1  misaligned store
- m_bad_addr  in  32  data address of the M-stage load/store
- mtc0_we  in  1  MTC0 in M
- cp0_waddr  in  5  MTC0 target register
- cp0_wdata  in  32  MTC0 data
- cp0_raddr  in  5  MFC0 source register
- cp0_rdata  out  32  MFC0 read data, combinational
- exc_flush  out  1  flush F/D/E/M and redirect
- exc_pc  out  32  redirect target
- timer_int  out  1  Cause.TI (bit 30)

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous and active-low.
- Reset values:
  - Status=STATUS_RST; Cause, EPC, BadVAddr, Count and Compare = 0; the tick flop = 0.
  - Outputs: exc_flush=0, timer_int=0, exc_pc=EXC_VECTOR.
  - Asserting resetn mid-exception discards any pending update.
- Interrupt pending: int_pend = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
  - Cause.IP[7:2] is sampled every cycle as {int_i[5]|TI, int_i[4:0]}.
  - Cause.IP[1:0] are software bits, written by MTC0.
- Exception detection is combinational, qualified by m_valid. Priority, highest first, with ExcCode:
  - interrupt 0x00
  - AdEL-fetch 0x04, BadVAddr=m_pc
  - RI 0x0A
  - Ov 0x0C
  - Sys 0x08
  - Bp 0x09
  - AdEL-data 0x04, BadVAddr=m_bad_addr
  - AdES 0x05, BadVAddr=m_bad_addr
  - ERET (not an exception)
- Redirect outputs:
  - exc_flush=1 in the same cycle as any exception or ERET.
  - exc_pc = EXC_VECTOR for exceptions, EPC for ERET.
- Register updates on the next rising edge after an exception is taken:
  - If Status.EXL=0: EPC = m_in_delay_slot ? m_pc-4 : m_pc, and Cause.BD = m_in_delay_slot.
  - If Status.EXL=1: EPC and BD are unchanged.
  - Always: Cause.ExcCode updated, Status.EXL=1, BadVAddr written only for address errors.
- ERET updates on the next edge: Status.EXL=0. ERET on a bubble is ignored.
- MTC0:
  - Takes effect on the next edge only when m_valid=1 and no exception/ERET is taken that cycle; it is suppressed otherwise.
  - Writable fields: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; EPC, Count and Compare in full.
  - BadVAddr and all other fields are read-only. Writes to unimplemented registers are dropped.
  - If an exception and an MTC0 target the same register in the same cycle, the exception wins.
- Timer:
  - The tick flop toggles every cycle; Count increments by 1 when tick=1, i.e. at half clock rate, wrapping from 0xFFFFFFFF to 0.
  - An MTC0 write to Count overrides the increment in that cycle.
  - TI is set when Count==Compare and stays set until an MTC0 write to Compare, which clears it.
  - timer_int = TI.
- Read path: cp0_rdata = register[cp0_raddr], combinational, with no write bypass. Unimplemented addresses read 0.

Test Plan:
- Reset: release resetn, read regs 12, 13 and 14 -> 0x00400000, 0, 0; exc_flush=0; exc_pc=0xBFC00380.
- Syscall: m_valid=1, m_syscall=1, m_pc=0xBFC00100, not in a delay slot -> same cycle exc_flush=1, exc_pc=0xBFC00380. Next cycle: EPC=0xBFC00100, Cause[6:2]=0x08, Status.EXL=1.
- Delay-slot break at m_pc=0xBFC00204 -> EPC=0xBFC00200, Cause.BD=1, ExcCode 0x09.
  - A second syscall while EXL=1 -> EPC unchanged.
- Priority:
  - m_reserve+m_overflow+m_syscall together -> ExcCode 0x0A.
  - m_adel_data with m_bad_addr=0x00000003 -> ExcCode 0x04, BadVAddr=0x00000003.
  - m_ades concurrently with mtc0_we to EPC -> EPC not overwritten by the MTC0.
- Timer:
  - Set Count=0, Compare=5 -> after 10 cycles timer_int=1 and Cause bit 30 = 1.
  - With Status.IM7=1 and IE=1, the next valid instruction -> exc_flush=1 with ExcCode 0x00.
  - MTC0 to Compare -> timer_int=0.
- ERET: with EPC=0xBFC00300 and EXL=1, m_eret=1 -> exc_flush=1 and exc_pc=0xBFC00300; next cycle EXL=0.
  - The same ERET with m_valid=0 -> no flush.
  - Assert resetn during a pending exception -> all registers back to their reset values.

Source files
------------

// File: rtl/cp0_exception_unit.sv
// rtl/cp0_exception_unit.sv - CP0 register file and M-stage exception arbiter with Count/Compare timer
module cp0_exception_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  int_i,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_in_delay_slot,
  input  logic        m_syscall,
  input  logic        m_break,
  input  logic        m_reserve,
  input  logic        m_eret,
  input  logic        m_overflow,
  input  logic        m_adel_if,
  input  logic        m_adel_data,
  input  logic        m_ades,
  input  logic [31:0] m_bad_addr,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic        exc_flush,
  output logic [31:0] exc_pc,
  output logic        timer_int
);

  localparam logic [4:0]  R_BADVADDR   = 5'd8;
  localparam logic [4:0]  R_COUNT      = 5'd9;
  localparam logic [4:0]  R_COMPARE    = 5'd11;
  localparam logic [4:0]  R_STATUS     = 5'd12;
  localparam logic [4:0]  R_CAUSE      = 5'd13;
  localparam logic [4:0]  R_EPC        = 5'd14;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  logic [31:0] badvaddr, count, compare, status, epc, cause;
  logic        cause_bd, cause_ti, tick;
  logic [7:0]  cause_ip;
  logic [4:0]  cause_exc;

  logic        int_pend, exc_taken, eret_taken, addr_err, mtc0_go;
  logic [4:0]  exc_code;
  logic [31:0] bad_addr_sel;

  assign cause = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exc, 2'b00};

  assign int_pend = status[0] & ~status[1] & (|(cause_ip & status[15:8]));

  always_comb begin
    exc_taken    = 1'b0;
    exc_code     = 5'h00;
    addr_err     = 1'b0;
    bad_addr_sel = m_bad_addr;
    if (m_valid) begin
      if (int_pend) begin
        exc_taken = 1'b1;
        exc_code  = 5'h00;
      end else if (m_adel_if) begin
        exc_taken    = 1'b1;
        exc_code     = 5'h04;
        addr_err     = 1'b1;
        bad_addr_sel = m_pc;
      end else if (m_reserve) begin
        exc_taken = 1'b1;
        exc_code  = 5'h0A;
      end else if (m_overflow) begin
        exc_taken = 1'b1;
        exc_code  = 5'h0C;
      end else if (m_syscall) begin
        exc_taken = 1'b1;
        exc_code  = 5'h08;
      end else if (m_break) begin
        exc_taken = 1'b1;
        exc_code  = 5'h09;
      end else if (m_adel_data) begin
        exc_taken = 1'b1;
        exc_code  = 5'h04;
        addr_err  = 1'b1;
      end else if (m_ades) begin
        exc_taken = 1'b1;
        exc_code  = 5'h05;
        addr_err  = 1'b1;
      end
    end
  end

  // MTC0 only commits when the instruction survives; any redirect suppresses it.
  assign eret_taken = m_valid & m_eret & ~exc_taken;
  assign mtc0_go    = m_valid & mtc0_we & ~exc_taken & ~eret_taken;

  assign exc_flush = exc_taken | eret_taken;
  assign exc_pc    = eret_taken ? epc : EXC_VECTOR;
  assign timer_int = cause_ti;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr  <= 32'd0;
      count     <= 32'd0;
      compare   <= 32'd0;
      status    <= STATUS_RST;
      epc       <= 32'd0;
      cause_bd  <= 1'b0;
      cause_ti  <= 1'b0;
      cause_ip  <= 8'd0;
      cause_exc <= 5'd0;
      tick      <= 1'b0;
    end else begin
      tick          <= ~tick;
      cause_ip[7:2] <= {int_i[5] | cause_ti, int_i[4:0]};

      if (mtc0_go && cp0_waddr == R_COUNT) count <= cp0_wdata;
      else                                 count <= count + {31'd0, tick};

      // Writing Compare acknowledges the timer even if it matches this cycle.
      if (mtc0_go && cp0_waddr == R_COMPARE) cause_ti <= 1'b0;
      else if (count == compare)             cause_ti <= 1'b1;

      if (exc_taken) begin
        if (!status[1]) begin
          epc      <= m_in_delay_slot ? m_pc - 32'd4 : m_pc;
          cause_bd <= m_in_delay_slot;
        end
        cause_exc <= exc_code;
        status[1] <= 1'b1;
        if (addr_err) badvaddr <= bad_addr_sel;
      end else if (eret_taken) begin
        status[1] <= 1'b0;
      end else if (mtc0_go) begin
        case (cp0_waddr)
          R_COMPARE: compare       <= cp0_wdata;
          R_STATUS:  status        <= (status & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
          R_CAUSE:   cause_ip[1:0] <= cp0_wdata[9:8];
          R_EPC:     epc           <= cp0_wdata;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_raddr)
      R_BADVADDR: cp0_rdata = badvaddr;
      R_COUNT:    cp0_rdata = count;
      R_COMPARE:  cp0_rdata = compare;
      R_STATUS:   cp0_rdata = status;
      R_CAUSE:    cp0_rdata = cause;
      R_EPC:      cp0_rdata = epc;
      default:    cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb/tb_cp0_exception_unit.sv - randomized check of cp0_exception_unit against an architectural register-file model
module tb_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  int_i;
  logic        m_valid, m_in_delay_slot, m_syscall, m_break, m_reserve, m_eret;
  logic        m_overflow, m_adel_if, m_adel_data, m_ades, mtc0_we;
  logic [31:0] m_pc, m_bad_addr, cp0_wdata, cp0_rdata, exc_pc;
  logic [4:0]  cp0_waddr, cp0_raddr;
  logic        exc_flush, timer_int;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cp0_exception_unit dut (
    .clk(clk), .resetn(resetn), .int_i(int_i), .m_valid(m_valid), .m_pc(m_pc),
    .m_in_delay_slot(m_in_delay_slot), .m_syscall(m_syscall), .m_break(m_break),
    .m_reserve(m_reserve), .m_eret(m_eret), .m_overflow(m_overflow), .m_adel_if(m_adel_if),
    .m_adel_data(m_adel_data), .m_ades(m_ades), .m_bad_addr(m_bad_addr), .mtc0_we(mtc0_we),
    .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
    .exc_flush(exc_flush), .exc_pc(exc_pc), .timer_int(timer_int)
  );

  // Architectural view: CP0 registers by number; unimplemented numbers stay zero.
  logic [31:0] mr [0:31];
  bit          mtick;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_comb(output bit exc, output bit eret, output logic [4:0] code,
                                     output bit aerr, output logic [31:0] bva);
    logic [4:0] tbl [0:7];
    bit [7:0]   cond;
    bit         ipend;
    tbl   = '{5'h00, 5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};
    ipend = mr[12][0] && !mr[12][1] && ((mr[13][15:8] & mr[12][15:8]) != 8'd0);
    cond  = {m_ades, m_adel_data, m_break, m_syscall, m_overflow, m_reserve, m_adel_if, ipend};
    exc = 0; code = 0; aerr = 0; bva = 0;
    if (m_valid)
      for (int i = 0; i < 8; i++)
        if (cond[i] && !exc) begin
          exc  = 1;
          code = tbl[i];
          aerr = (i == 1) || (i >= 6);
          bva  = (i == 1) ? m_pc : m_bad_addr;
        end
    eret = m_valid && m_eret && !exc;
  endfunction

  task automatic model_step();
    logic [31:0] nr [0:31];
    bit exc, eret, aerr, wr;
    logic [4:0] code;
    logic [31:0] bva;
    model_comb(exc, eret, code, aerr, bva);
    nr = mr;
    wr = m_valid && mtc0_we && !exc && !eret;
    nr[9] = (wr && cp0_waddr == 9) ? cp0_wdata : mr[9] + (mtick ? 32'd1 : 32'd0);
    if (wr && cp0_waddr == 11)  nr[13][30] = 1'b0;
    else if (mr[9] == mr[11])   nr[13][30] = 1'b1;
    nr[13][15:10] = {int_i[5] | mr[13][30], int_i[4:0]};
    if (exc) begin
      if (!mr[12][1]) begin
        nr[14]     = m_in_delay_slot ? m_pc - 32'd4 : m_pc;
        nr[13][31] = m_in_delay_slot;
      end
      nr[13][6:2] = code;
      nr[12][1]   = 1'b1;
      if (aerr) nr[8] = bva;
    end else if (eret) begin
      nr[12][1] = 1'b0;
    end else if (wr) begin
      case (cp0_waddr)
        5'd11: nr[11] = cp0_wdata;
        5'd12: nr[12] = (mr[12] & ~32'h0000FF03) | (cp0_wdata & 32'h0000FF03);
        5'd13: nr[13][9:8] = cp0_wdata[9:8];
        5'd14: nr[14] = cp0_wdata;
        default: ;
      endcase
    end
    mr = nr;
    mtick = !mtick;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      foreach (mr[i]) mr[i] = 32'd0;
      mr[12] = 32'h00400000;
      mtick  = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    bit exc, eret, aerr;
    logic [4:0] code;
    logic [31:0] bva;
    model_comb(exc, eret, code, aerr, bva);
    chk("exc_flush", {31'd0, exc_flush}, {31'd0, exc || eret});
    chk("exc_pc", exc_pc, eret ? mr[14] : 32'hBFC00380);
    chk("timer_int", {31'd0, timer_int}, {31'd0, mr[13][30]});
    chk("cp0_rdata", cp0_rdata, mr[cp0_raddr]);
  end

  task automatic idle();
    int_i = 6'd0; m_valid = 0; m_pc = 32'd0; m_in_delay_slot = 0;
    m_syscall = 0; m_break = 0; m_reserve = 0; m_eret = 0; m_overflow = 0;
    m_adel_if = 0; m_adel_data = 0; m_ades = 0; m_bad_addr = 32'd0;
    mtc0_we = 0; cp0_waddr = 5'd0; cp0_wdata = 32'd0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_raddr = a;
    #1;
    d = cp0_rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    m_valid = 1; mtc0_we = 1; cp0_waddr = a; cp0_wdata = d;
  endtask

  initial begin
    logic [31:0] d;
    resetn = 0;
    idle();
    cp0_raddr = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    rd(12, d); chk("rst_status", d, 32'h00400000);
    rd(13, d); chk("rst_cause", d, 32'd0);
    rd(14, d); chk("rst_epc", d, 32'd0);
    chk("rst_flush", {31'd0, exc_flush}, 32'd0);
    chk("rst_exc_pc", exc_pc, 32'hBFC00380);
    resetn = 1;

    next(); m_valid = 1; m_syscall = 1; m_pc = 32'hBFC00100;
    #1; chk("sys_flush", {31'd0, exc_flush}, 32'd1); chk("sys_pc", exc_pc, 32'hBFC00380);
    next();
    rd(14, d); chk("sys_epc", d, 32'hBFC00100);
    rd(13, d); chk("sys_code", {27'd0, d[6:2]}, 32'h08);
    rd(12, d); chk("sys_exl", {31'd0, d[1]}, 32'd1);

    next(); mtc0(12, 32'd0);
    next(); m_valid = 1; m_break = 1; m_pc = 32'hBFC00204; m_in_delay_slot = 1;
    next();
    rd(14, d); chk("bp_epc", d, 32'hBFC00200);
    rd(13, d); chk("bp_bd", {31'd0, d[31]}, 32'd1); chk("bp_code", {27'd0, d[6:2]}, 32'h09);
    m_valid = 1; m_syscall = 1; m_pc = 32'hBFC00500;
    next();
    rd(14, d); chk("exl_epc_hold", d, 32'hBFC00200);

    next(); m_valid = 1; m_reserve = 1; m_overflow = 1; m_syscall = 1;
    next(); rd(13, d); chk("prio_ri", {27'd0, d[6:2]}, 32'h0A);
    m_valid = 1; m_adel_data = 1; m_bad_addr = 32'h00000003;
    next();
    rd(13, d); chk("adel_code", {27'd0, d[6:2]}, 32'h04);
    rd(8, d);  chk("adel_bva", d, 32'h00000003);
    m_ades = 1; m_bad_addr = 32'h00000010; mtc0(14, 32'h12345678);
    next();
    rd(14, d); chk("ades_epc_kept", d, 32'hBFC00200);
    rd(13, d); chk("ades_code", {27'd0, d[6:2]}, 32'h05);

    next(); mtc0(12, 32'd0);
    next(); mtc0(9, 32'd0);
    next(); mtc0(11, 32'd5);
    repeat (14) next();
    chk("timer_set", {31'd0, timer_int}, 32'd1);
    rd(13, d); chk("cause_ti", {31'd0, d[30]}, 32'd1);
    mtc0(12, 32'h00008001);
    next(); m_valid = 1;
    #1; chk("int_flush", {31'd0, exc_flush}, 32'd1);
    next(); rd(13, d); chk("int_code", {27'd0, d[6:2]}, 32'h00);
    mtc0(11, 32'hFFFF0000);
    next(); chk("timer_clr", {31'd0, timer_int}, 32'd0);

    mtc0(14, 32'hBFC00300);
    next(); m_valid = 1; m_eret = 1;
    #1; chk("eret_flush", {31'd0, exc_flush}, 32'd1); chk("eret_pc", exc_pc, 32'hBFC00300);
    next(); rd(12, d); chk("eret_exl", {31'd0, d[1]}, 32'd0);
    m_eret = 1; m_valid = 0;
    #1; chk("eret_bubble", {31'd0, exc_flush}, 32'd0);

    next(); m_valid = 1; m_syscall = 1; m_pc = 32'hBFC00700;
    #1; resetn = 0;
    rd(12, d); chk("mid_rst_status", d, 32'h00400000);
    rd(13, d); chk("mid_rst_cause", d, 32'd0);
    rd(14, d); chk("mid_rst_epc", d, 32'd0);
    next(); resetn = 1;

    repeat (3000) begin
      next();
      m_valid         = ($urandom_range(0, 3) != 0);
      m_pc            = $urandom;
      m_bad_addr      = $urandom;
      m_in_delay_slot = $urandom_range(0, 1) == 1;
      m_syscall       = $urandom_range(0, 15) == 0;
      m_break         = $urandom_range(0, 15) == 0;
      m_reserve       = $urandom_range(0, 15) == 0;
      m_eret          = $urandom_range(0, 9) == 0;
      m_overflow      = $urandom_range(0, 15) == 0;
      m_adel_if       = $urandom_range(0, 19) == 0;
      m_adel_data     = $urandom_range(0, 15) == 0;
      m_ades          = $urandom_range(0, 15) == 0;
      int_i           = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      mtc0_we         = $urandom_range(0, 2) == 0;
      case ($urandom_range(0, 6))
        0: cp0_waddr = 5'd8;
        1: cp0_waddr = 5'd9;
        2: cp0_waddr = 5'd11;
        3: cp0_waddr = 5'd12;
        4: cp0_waddr = 5'd13;
        5: cp0_waddr = 5'd14;
        default: cp0_waddr = 5'($urandom);
      endcase
      cp0_wdata = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom;
      cp0_raddr = 5'($urandom_range(0, 15));
    end

    next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
